pal_macrocell_array: RTL
========================

# pal_macrocell_array

Parametrised second-generation PAL core: a programmable AND/OR array with per-output macrocells (combinational, inverted, D-registered, T-registered). It is configured over a single-clock serial bitstream port with bit counting, length checking and serial readback. It sits behind the TT top wrapper in place of the first-generation array. Outputs are held low until a correct-length bitstream has been loaded.

## Interface
- NUM_INPUTS, 8, number of array inputs I[n].
- NUM_TERMS, 13, number of product terms.
- NUM_OUTPUTS, 4, number of outputs/macrocells.
- Derived: AND_BITS = 2·NUM_INPUTS·NUM_TERMS; OR_BITS = NUM_TERMS·NUM_OUTPUTS; MC_BITS = 2·NUM_OUTPUTS; CFG_LEN = AND_BITS+OR_BITS+MC_BITS (268 at defaults).

Ports:
- clk  in  1  single clock. All flops are rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_mode  in  1  1 = configuration phase; array outputs forced 0.
- cfg_valid  in  1  accept cfg_data this cycle (only while cfg_mode=1).
- cfg_data  in  1  serial configuration bit.
- cfg_dout  out  1  serial readback/daisy-chain bit (chain[0]).
- cfg_done  out  1  last configuration phase loaded exactly CFG_LEN bits.
- cfg_err  out  1  last configuration phase loaded ≠ CFG_LEN bits.
- enable  in  1  output enable.
- in_data  in  NUM_INPUTS  array inputs.
- out_data  out  NUM_OUTPUTS  array outputs.

## Operation
- Config chain: a CFG_LEN-bit register. An accepted bit shifts: chain ← {cfg_data, chain[CFG_LEN-1:1]}. The first bit sent therefore ends at index 0 (LSB-first stream).
- Bit map:
  - Term t, input i: chain[2·NUM_INPUTS·t+2i] enables true literal I[i]; chain[…+2i+1] enables complement ~I[i].
  - OR bit for output o, term t: chain[AND_BITS + o·NUM_TERMS + t].
  - Macrocell mode for output o: chain[AND_BITS+OR_BITS+2o +: 2].
- Term t = AND of enabled literals. A term with no enabled literal evaluates to 0. Comb[o] = OR of selected terms; 0 if none are selected.
- Macrocell modes:
  - 00 = comb.
  - 01 = D flop (q ← comb).
  - 10 = T flop (q ← q ^ comb).
  - 11 = ~comb.
- Macrocell flops advance only when run = cfg_done & ~cfg_mode & enable; otherwise they hold. They are forced to 0 while cfg_mode=1.
- out_data[o] = run ? mc_out[o] : 0. Each output uses only its own OR row and macrocell bits; no cross-output aliasing.
- Bit counter: width $clog2(CFG_LEN+2). It saturates at CFG_LEN+1.
- Entering config (cfg_mode sampled 0→1 via registered cfg_mode_q):
  - counter ← cfg_valid ? 1 : 0;
  - cfg_done ← 0, cfg_err ← 0;
  - chain is not cleared.
- Leaving config (1→0): cfg_done ← (cnt==CFG_LEN); cfg_err ← (cnt≠CFG_LEN).
- cfg_valid with cfg_mode=0 is ignored. The chain and counter hold.
- Reset values: chain 0, counter 0, cfg_mode_q 0, flops 0, cfg_done 0, cfg_err 0, cfg_dout 0, out_data 0.
- Reset mid-load aborts the load: all state returns to reset values and a full reload is required.

## Timing
- One bit accepted per cycle with cfg_valid=1. There is no backpressure.
- cfg_dout shows chain[0] before the shift and updates one cycle after each accepted bit. Shifting CFG_LEN bits reproduces the prior contents LSB-first.
- cfg_done/cfg_err are registered. They are valid the cycle after cfg_mode is sampled low.
- Modes 00/11: out_data is combinational from in_data and enable (0-cycle).
- Mode 01: out_data reflects in_data one clk after sampling. Mode 10 toggles on each edge where comb=1 and run=1.
- Dropping enable forces out_data to 0 combinationally and freezes flop state. Re-asserting enable restores the held value immediately.

## Test plan
- Reset: rst_n=0 mid-operation → out_data=0, cfg_done=0, cfg_err=0, cfg_dout=0 asynchronously. Assert again after 100 of 268 bits → the next exit without reload gives cfg_err=1.
- Functional load (268 bits, defaults): O0=~I0 (00), O1=I1&I2 (00), O2=I3 (01), O3=I4 (10).
  - Exit config, enable=1.
  - in_data=8'h00 → out_data=4'b0001. 8'h06 → 4'b0011.
  - 8'h08 → O2=1 one cycle later.
  - 8'h10 held 3 cycles → O3 toggles 1,0,1.
  - Distinct patterns on each output (aliasing regression).
- Length check: loads of 267 and 269 bits → cfg_err=1, cfg_done=0, out_data=0 with enable=1. A load of 268 bits → cfg_done=1, cfg_err=0.
- Enable gating: with O3 T-flop at 1, drop enable for 10 cycles with in_data=8'h10 → out_data=0. Re-assert → O3=1 immediately (state held), then toggles.
- Readback: load an alternating 1010… pattern. Re-enter config and shift 268 zeros → cfg_dout emits the original bits index 0 first. Then exit → cfg_done=1 and all outputs 0 (all-zero array).
- Mode 11 and empty terms: program O0 as mode 11 with no terms selected → out_data[0]=1 for all inputs. cfg_valid pulses with cfg_mode=0 leave outputs and cfg_dout unchanged.

Source files
------------

// File: rtl/pal_macrocell_array.sv
// pal_macrocell_array: second-generation PAL core.
// A programmable AND/OR array feeds per-output macrocells. Each macrocell is
// combinational, inverted, D-registered or T-registered. The whole personality
// lives in one serial configuration chain, which is loaded LSB-first and can be
// read back through cfg_dout. Outputs stay low until a load of exactly CFG_LEN
// bits has completed.
module pal_macrocell_array #(
  parameter int NUM_INPUTS  = 8,
  parameter int NUM_TERMS   = 13,
  parameter int NUM_OUTPUTS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_mode,
  input  logic                   cfg_valid,
  input  logic                   cfg_data,
  output logic                   cfg_dout,
  output logic                   cfg_done,
  output logic                   cfg_err,
  input  logic                   enable,
  input  logic [NUM_INPUTS-1:0]  in_data,
  output logic [NUM_OUTPUTS-1:0] out_data
);

  localparam int AND_BITS = 2 * NUM_INPUTS * NUM_TERMS;
  localparam int OR_BITS  = NUM_TERMS * NUM_OUTPUTS;
  localparam int MC_BITS  = 2 * NUM_OUTPUTS;
  localparam int CFG_LEN  = AND_BITS + OR_BITS + MC_BITS;
  localparam int CNT_W    = $clog2(CFG_LEN + 2);
  localparam int LIT_W    = 2 * NUM_INPUTS;

  localparam logic [CNT_W-1:0] CNT_LEN  = CNT_W'(CFG_LEN);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CFG_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  localparam logic [1:0] MODE_COMB = 2'b00;
  localparam logic [1:0] MODE_DFF  = 2'b01;
  localparam logic [1:0] MODE_TFF  = 2'b10;
  localparam logic [1:0] MODE_INV  = 2'b11;

  logic [CFG_LEN-1:0]     chain;
  logic [CNT_W-1:0]       cnt;
  logic                   cfg_mode_q;
  logic [NUM_OUTPUTS-1:0] mc_q;
  logic [NUM_OUTPUTS-1:0] mc_out;
  logic [NUM_OUTPUTS-1:0] comb;
  logic [NUM_TERMS-1:0]   term;
  logic [LIT_W-1:0]       lit;
  logic                   run;

  // The array and the flops only run after a clean load, outside config, when enabled.
  assign run = cfg_done & ~cfg_mode & enable;

  // The readback bit is the chain LSB, which is already a flop.
  assign cfg_dout = chain[0];

  // Interleave the true and complement literals so that they line up with the AND-plane bit pairs.
  always_comb begin
    lit = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      lit[2*i]   = in_data[i];
      lit[2*i+1] = ~in_data[i];
    end
  end

  // A product term is the AND of its enabled literals. A term with no enabled literal reads as 0.
  for (genvar t = 0; t < NUM_TERMS; t++) begin : g_term
    logic [LIT_W-1:0] mask;
    assign mask    = chain[LIT_W*t +: LIT_W];
    assign term[t] = (|mask) & (&(~mask | lit));
  end

  // Each output ORs only the terms selected in its own OR row.
  for (genvar o = 0; o < NUM_OUTPUTS; o++) begin : g_or
    assign comb[o] = |(term & chain[AND_BITS + o*NUM_TERMS +: NUM_TERMS]);
  end

  // Macrocell output select: pass, invert, or the registered state for the flop modes.
  always_comb begin
    mc_out = '0;
    for (int o = 0; o < NUM_OUTPUTS; o++) begin
      case (chain[AND_BITS + OR_BITS + 2*o +: 2])
        MODE_COMB: mc_out[o] = comb[o];
        MODE_DFF:  mc_out[o] = mc_q[o];
        MODE_TFF:  mc_out[o] = mc_q[o];
        MODE_INV:  mc_out[o] = ~comb[o];
        default:   mc_out[o] = 1'b0;
      endcase
    end
  end

  // Outputs are gated combinationally, so dropping enable zeroes them at once while the state holds.
  always_comb begin
    if (run) begin
      out_data = mc_out;
    end else begin
      out_data = '0;
    end
  end

  // Macrocell flops clear during config, advance when run is high, and otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mc_q <= '0;
    end else if (cfg_mode) begin
      mc_q <= '0;
    end else if (run) begin
      for (int o = 0; o < NUM_OUTPUTS; o++) begin
        case (chain[AND_BITS + OR_BITS + 2*o +: 2])
          MODE_DFF: mc_q[o] <= comb[o];
          MODE_TFF: mc_q[o] <= mc_q[o] ^ comb[o];
          default:  mc_q[o] <= mc_q[o];
        endcase
      end
    end else begin
      mc_q <= mc_q;
    end
  end

  // The configuration chain shifts one accepted bit in at the top. Bits sent first end up at the LSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else if (cfg_mode && cfg_valid) begin
      chain <= {cfg_data, chain[CFG_LEN-1:1]};
    end else begin
      chain <= chain;
    end
  end

  // Count bits per config phase on the cfg_mode edges, and judge the length when config is left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_mode_q <= 1'b0;
      cnt        <= CNT_ZERO;
      cfg_done   <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_mode_q <= cfg_mode;
      if (cfg_mode && !cfg_mode_q) begin
        cnt      <= cfg_valid ? CNT_ONE : CNT_ZERO;
        cfg_done <= 1'b0;
        cfg_err  <= 1'b0;
      end else if (cfg_mode) begin
        if (cfg_valid && (cnt != CNT_SAT)) begin
          cnt <= cnt + CNT_ONE;
        end else begin
          cnt <= cnt;
        end
      end else if (cfg_mode_q) begin
        cfg_done <= (cnt == CNT_LEN);
        cfg_err  <= (cnt != CNT_LEN);
      end else begin
        cnt <= cnt;
      end
    end
  end

endmodule
